// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, runs a single-outstanding request/response
// handshake to instruction memory and presents the decoded fields of the held word.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        zero,
    input  logic        branch,
    input  logic        pcsrc_j,
    input  logic        pcsrc_jal,
    input  logic        pcsrc_jr,
    input  logic [31:0] jr_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm16,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        inst_valid,
    output logic        misalign,
    output logic        fetch_err
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {ISSUE, WAIT, HOLD} state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [31:0]   next_pc;
    logic [31:0]   branch_off;
    logic          capture;
    logic          consume;
    logic          timeout;

    assign opcode   = instr[31:26];
    assign rs       = instr[25:21];
    assign rt       = instr[20:16];
    assign rd       = instr[15:11];
    assign shamt    = instr[10:6];
    assign funct    = instr[5:0];
    assign imm16    = instr[15:0];
    assign pc_plus4 = pc + 32'd4;

    // Request is masked while reset is held so nothing is accepted mid-reset.
    assign imem_req  = (state == ISSUE) && !reset;
    assign imem_addr = pc;

    assign capture    = (state == WAIT) && imem_rvalid;
    assign timeout    = (state == WAIT) && !imem_rvalid && (cnt == CNT_LAST);
    assign consume    = (state == HOLD) && inst_valid && !stall;
    assign branch_off = {{14{imm16[15]}}, imm16, 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        if (pcsrc_jr) begin
            next_pc = {jr_target[31:2], 2'b00};
        end else if (pcsrc_j || pcsrc_jal) begin
            next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
        end else if (branch && zero) begin
            next_pc = pc_plus4 + branch_off;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            ISSUE: begin
                if (imem_ready) begin
                    state_next = WAIT;
                    cnt_next   = '0;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    state_next = HOLD;
                end else if (timeout) begin
                    state_next = ISSUE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            HOLD: begin
                if (consume) begin
                    state_next = ISSUE;
                end
            end
            default: state_next = ISSUE;
        endcase
    end

    // A timeout returns to ISSUE with pc untouched, so the same word is re-requested.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ISSUE;
            cnt        <= '0;
            pc         <= {RESET_PC[31:2], 2'b00};
            instr      <= '0;
            inst_valid <= 1'b0;
            misalign   <= 1'b0;
            fetch_err  <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            misalign  <= consume && pcsrc_jr && (jr_target[1:0] != 2'b00);
            fetch_err <= timeout;
            if (capture) begin
                instr      <= imem_rdata;
                inst_valid <= 1'b1;
            end
            if (consume) begin
                pc         <= next_pc;
                inst_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: the bench plays instruction memory and the
// control unit; expected fetch addresses are queued on consume and popped on each request.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          TIMEOUT  = 16;

    localparam int MODE_NORMAL     = 0;
    localparam int MODE_RESET_WAIT = 1;
    localparam int MODE_RESET_HOLD = 2;
    localparam int MODE_TIMEOUT    = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        zero;
    logic        branch;
    logic        pcsrc_j;
    logic        pcsrc_jal;
    logic        pcsrc_jr;
    logic [31:0] jr_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        inst_valid;
    logic        misalign;
    logic        fetch_err;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] exp_addr[$];

    fetch_unit #(
        .RESET_PC(RESET_PC),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .zero       (zero),
        .branch     (branch),
        .pcsrc_j    (pcsrc_j),
        .pcsrc_jal  (pcsrc_jal),
        .pcsrc_jr   (pcsrc_jr),
        .jr_target  (jr_target),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .opcode     (opcode),
        .rs         (rs),
        .rt         (rt),
        .rd         (rd),
        .shamt      (shamt),
        .funct      (funct),
        .imm16      (imm16),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .inst_valid (inst_valid),
        .misalign   (misalign),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    // Hard stop in case a handshake never completes.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got hang expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic randomizeControls();
        branch    = 1'($urandom);
        zero      = 1'($urandom);
        pcsrc_j   = 1'($urandom);
        pcsrc_jal = 1'($urandom);
        pcsrc_jr  = 1'($urandom);
        jr_target = $urandom;
    endtask

    // Pulses reset for one edge; called at a negedge, returns at a negedge.
    task automatic doReset();
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        stall       = 1'b0;
        reset       = 1'b1;
        @(negedge clk);
        checkOutput("rst_inst_valid", inst_valid, 0);
        checkOutput("rst_imem_req", imem_req, 0);
        checkOutput("rst_pc", pc, RESET_PC);
        checkOutput("rst_instr", instr, 0);
        checkOutput("rst_misalign", misalign, 0);
        checkOutput("rst_fetch_err", fetch_err, 0);
        reset = 1'b0;
        exp_addr.delete();
        exp_addr.push_back(RESET_PC);
        @(negedge clk);
    endtask

    // One fetch transaction; called at a negedge, returns at a negedge.
    task automatic applyStimulus(input logic [31:0] word,
                                 input logic br, input logic zr,
                                 input logic j, input logic jal, input logic jr,
                                 input logic [31:0] jrt,
                                 input int stall_cycles, input int ready_delay,
                                 input int resp_delay, input int mode);
        int          n;
        int          k;
        logic [31:0] exp;
        logic [31:0] ppc;
        logic [31:0] nexp;
        logic        exp_mis;

        randomizeControls();
        n = 0;
        while (!imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("req_seen", imem_req, 1);
        checkOutput("sb_nonempty", (exp_addr.size() != 0), 1);
        exp = (exp_addr.size() != 0) ? exp_addr.pop_front() : 32'hDEAD_BEEF;
        checkOutput("imem_addr", imem_addr, exp);

        for (int i = 0; i < ready_delay; i++) begin
            imem_ready = 1'b0;
            @(negedge clk);
            checkOutput("req_held", imem_req, 1);
            checkOutput("addr_held", imem_addr, exp);
        end
        imem_ready = 1'b1;
        @(negedge clk);
        imem_ready = 1'b0;
        checkOutput("req_drop", imem_req, 0);

        if (mode == MODE_TIMEOUT) begin
            imem_rvalid = 1'b0;
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!fetch_err && k < TIMEOUT + 4);
            checkOutput("timeout_cycles", k, TIMEOUT);
            checkOutput("retry_req", imem_req, 1);
            checkOutput("retry_addr", imem_addr, exp);
            @(negedge clk);
            checkOutput("fetch_err_pulse", fetch_err, 0);
            exp_addr.push_front(exp);
            return;
        end

        if (mode == MODE_RESET_WAIT) begin
            repeat (2) @(negedge clk);
            doReset();
            return;
        end

        for (int i = 0; i < resp_delay; i++) begin
            imem_rvalid = 1'b0;
            @(negedge clk);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = word;
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;

        checkOutput("inst_valid", inst_valid, 1);
        checkOutput("instr", instr, word);
        checkOutput("opcode", opcode, {26'd0, word[31:26]});
        checkOutput("rs", rs, {27'd0, word[25:21]});
        checkOutput("rt", rt, {27'd0, word[20:16]});
        checkOutput("rd", rd, {27'd0, word[15:11]});
        checkOutput("shamt", shamt, {27'd0, word[10:6]});
        checkOutput("funct", funct, {26'd0, word[5:0]});
        checkOutput("imm16", imm16, {16'd0, word[15:0]});
        checkOutput("pc", pc, exp);
        checkOutput("pc_plus4", pc_plus4, exp + 32'd4);
        checkOutput("hold_no_req", imem_req, 0);

        if (mode == MODE_RESET_HOLD) begin
            doReset();
            return;
        end

        for (int i = 0; i < stall_cycles; i++) begin
            stall = 1'b1;
            randomizeControls();
            @(negedge clk);
            checkOutput("stall_valid", inst_valid, 1);
            checkOutput("stall_instr", instr, word);
            checkOutput("stall_pc", pc, exp);
            checkOutput("stall_no_req", imem_req, 0);
        end

        stall     = 1'b0;
        branch    = br;
        zero      = zr;
        pcsrc_j   = j;
        pcsrc_jal = jal;
        pcsrc_jr  = jr;
        jr_target = jrt;

        ppc = exp + 32'd4;
        if (jr)
            nexp = {jrt[31:2], 2'b00};
        else if (j || jal)
            nexp = {ppc[31:28], word[25:0], 2'b00};
        else if (br && zr)
            nexp = ppc + {{14{word[15]}}, word[15:0], 2'b00};
        else
            nexp = ppc;
        exp_mis = jr && (jrt[1:0] != 2'b00);
        exp_addr.push_back(nexp);

        @(negedge clk);
        randomizeControls();
        checkOutput("consumed_valid", inst_valid, 0);
        checkOutput("next_req", imem_req, 1);
        checkOutput("next_addr", imem_addr, nexp);
        checkOutput("misalign", misalign, exp_mis);
        @(negedge clk);
        checkOutput("misalign_pulse", misalign, 0);
    endtask

    initial begin
        reset       = 1'b1;
        stall       = 1'b0;
        zero        = 1'b0;
        branch      = 1'b0;
        pcsrc_j     = 1'b0;
        pcsrc_jal   = 1'b0;
        pcsrc_jr    = 1'b0;
        jr_target   = '0;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        repeat (2) @(negedge clk);
        doReset();

        //            word           br zr j  jal jr jrt            stl rdy rsp mode
        applyStimulus(32'h2008_0005, 0, 0, 0, 0, 0, 32'h0,          0,  0,  0,  MODE_NORMAL);
        checkOutput("addi_opcode", {26'd0, opcode}, 32'h08);
        applyStimulus(32'h0800_0004, 0, 0, 1, 0, 0, 32'h0,          0,  0,  0,  MODE_NORMAL);
        applyStimulus(32'h1000_FFFF, 1, 1, 0, 0, 0, 32'h0,          0,  0,  1,  MODE_NORMAL);
        applyStimulus(32'h1000_FFFF, 1, 0, 0, 0, 0, 32'h0,          0,  1,  0,  MODE_NORMAL);
        applyStimulus(32'h03E0_0008, 0, 0, 0, 0, 1, 32'h9000_0000, 0,  0,  0,  MODE_NORMAL);
        applyStimulus(32'h0800_0040, 0, 0, 1, 0, 0, 32'h0,          0,  0,  0,  MODE_NORMAL);
        applyStimulus(32'h0100_0008, 0, 0, 0, 0, 1, 32'h0000_2002, 0,  0,  0,  MODE_NORMAL);
        applyStimulus(32'h2129_0001, 0, 0, 0, 0, 0, 32'h0,          5,  3,  2,  MODE_NORMAL);
        applyStimulus(32'h0C00_0800, 1, 1, 0, 1, 0, 32'h0,          0,  0,  0,  MODE_NORMAL);
        applyStimulus(32'h03E0_0008, 1, 1, 1, 0, 1, 32'hFFFF_FFFC, 0,  0,  0,  MODE_NORMAL);
        applyStimulus(32'h0000_0000, 0, 0, 0, 0, 0, 32'h0,          0,  0,  0,  MODE_NORMAL);
        applyStimulus(32'h0,         0, 0, 0, 0, 0, 32'h0,          0,  0,  0,  MODE_TIMEOUT);
        applyStimulus(32'h1000_0004, 1, 0, 0, 0, 0, 32'h0,          0,  0,  3,  MODE_NORMAL);
        applyStimulus(32'h0,         0, 0, 0, 0, 0, 32'h0,          0,  0,  0,  MODE_RESET_WAIT);
        applyStimulus(32'hAC8A_1234, 0, 0, 0, 0, 0, 32'h0,          0,  0,  0,  MODE_NORMAL);
        applyStimulus(32'h1234_5678, 0, 0, 0, 0, 0, 32'h0,          0,  0,  0,  MODE_RESET_HOLD);
        applyStimulus(32'h2008_0005, 0, 0, 0, 0, 0, 32'h0,          0,  0,  0,  MODE_NORMAL);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the control unit.
- Holds the PC and runs a request/response handshake to instruction memory.
- Registers the fetched word and splits it into fields (Opcode, funct, shamt, rs, rt, rd, imm), which go to the control unit and register file.
- Computes the next PC from the control unit's Branch/PCSrcJ/PCSrcJal/PCSrcJr outputs when the current instruction retires.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
TIMEOUT, 16, cycles to wait for imem_rvalid before re-issuing the request (must be ≥2).

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
stall  in  1  downstream hold; the current instruction is not consumed.
zero  in  1  ALU zero flag for the current instruction.
branch  in  1  Branch from the control unit.
pcsrc_j  in  1  PCSrcJ from the control unit.
pcsrc_jal  in  1  PCSrcJal from the control unit.
pcsrc_jr  in  1  PCSrcJr from the control unit.
jr_target  in  32  rs register value, used by jr.
imem_req  out  1  request valid.
imem_addr  out  32  word address of the request.
imem_ready  in  1  memory accepts the request this cycle.
imem_rvalid  in  1  response valid.
imem_rdata  in  32  response instruction word.
instr  out  32  registered instruction.
opcode  out  6  instr[31:26].
rs, rt, rd  out  5 each  instr[25:21], [20:16], [15:11].
shamt  out  5  instr[10:6].
funct  out  6  instr[5:0].
imm16  out  16  instr[15:0].
pc  out  32  address of instr.
pc_plus4  out  32  pc+4, link value for jal.
inst_valid  out  1  instr/fields are valid.
misalign  out  1  one-cycle pulse: jr_target[1:0]≠0 on a consumed jr.
fetch_err  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset (when reset=1 at an edge):
  - Outputs: pc=RESET_PC, instr=0, inst_valid=0, imem_req=0, misalign=0, fetch_err=0.
  - State: FSM=ISSUE, timeout counter=0.
  - Reset has priority over every other input.
  - Reset during WAIT abandons the outstanding request. The memory is reset on the same reset, so no stale response arrives.
- FSM states: ISSUE, WAIT, HOLD.
- ISSUE:
  - imem_req=1, imem_addr=pc.
  - If imem_ready, go to WAIT and clear the counter; otherwise stay, with imem_addr held stable.
  - imem_rvalid is ignored in ISSUE.
- WAIT:
  - imem_req=0.
  - If imem_rvalid: instr←imem_rdata, inst_valid←1, go to HOLD.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 without rvalid: fetch_err pulses, return to ISSUE with the same pc.
  - Only one request is outstanding at a time; a late response after a timeout is not supported.
- HOLD:
  - inst_valid=1; fields are stable.
  - Consume when inst_valid & ~stall at an edge. On consume: pc←next_pc, inst_valid←0, go to ISSUE.
  - If stall, stay in HOLD with all outputs unchanged.
- next_pc priority (evaluated only on consume):
  - pcsrc_jr: {jr_target[31:2],2'b00}; misalign pulses if jr_target[1:0]≠0.
  - else pcsrc_j|pcsrc_jal: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - else branch&zero: pc_plus4 + ({{14{imm16[15]}}, imm16, 2'b00}), 32-bit wrap-around.
  - else pc_plus4.
- Arithmetic: pc+4 wraps modulo 2^32 (32'hFFFF_FFFC → 0). pc[1:0] is always 00.
- Latency:
  - Reset → imem_req on the first cycle after reset deasserts.
  - Accept → earliest rvalid the next cycle.
  - rvalid → inst_valid the next cycle.
  - Consume → new imem_req the next cycle.
  - Minimum 3 cycles per instruction.
- Control inputs are sampled only on consume; they are don't-care in ISSUE and WAIT.

Test Plan:
- Reset, RESET_PC=0; memory returns 0x2008_0005 (addi) with 1-cycle latency, ready=1, stall=0 → imem_addr 0, then instr=0x2008_0005, opcode=6'b001000, rt=8, imm16=5; next imem_addr=4.
- Branch at pc=0x10 with imm16=0xFFFF, branch=1, zero=1 → next imem_addr=0x10; same with zero=0 → 0x14.
- j at pc=0x9000_0000 with instr[25:0]=0x0000_040 → next addr=0x9000_0100. jr with jr_target=0x0000_2002 → addr=0x0000_2000, misalign pulses once.
- stall=1 for 5 cycles in HOLD → instr/pc/inst_valid unchanged, no imem_req; stall drops → addr=pc+4 the next cycle.
- imem_ready low 3 cycles → imem_req/addr held stable. No rvalid for TIMEOUT=16 cycles → fetch_err pulses once and the same address is re-requested.
- Reset asserted in WAIT and in HOLD → following cycle inst_valid=0, imem_req=1, imem_addr=RESET_PC.
